hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk input 1, pipeline clock, rising edge.
REQ-002 SHALL have ports: rst input 1, reset; synchronous, active-high.
REQ-003 SHALL have ports: D_rs input 5, rs field of instruction in D stage.
REQ-004 SHALL have ports: D_rt input 5, rt field of instruction in D stage.
REQ-005 SHALL have ports: D_rs_tuse input 2, cycles until rs consumed (3 = not used).
REQ-006 SHALL have ports: D_rt_tuse input 2, cycles until rt consumed (3 = not used).
REQ-007 SHALL have ports: E_wa input 5, destination register of E-stage instruction (0 = none).
REQ-008 SHALL have ports: E_tnew input 2, cycles until E-stage result available.
REQ-009 SHALL have ports: M_wa input 5, destination register of M-stage instruction.
REQ-010 SHALL have ports: M_tnew input 2, cycles until M-stage result available.
REQ-011 SHALL have ports: D_md input 1, D-stage instruction uses mult/div unit or HI/LO.
REQ-012 SHALL have ports: E_start input 1, mult/div instruction issuing in E this cycle.
REQ-013 SHALL have ports: E_is_div input 1, qualifies E_start: 1 = div, 0 = mult.
REQ-014 SHALL have ports: stall output 1, freeze PC and F/D register.
REQ-015 SHALL have ports: DE_clr output 1, load bubble (all-zero) into D/E register.
REQ-016 SHALL have ports: busy output 1, mult/div unit occupied.
REQ-017 SHALL have ports: md_cnt output 4, remaining mult/div cycles.
REQ-018 SHALL have ports: stall_cnt output 32, total stall cycles since reset.

Function
REQ-019 SHALL compute stall_rs = (D_rs != 0) and ((D_rs == E_wa and E_tnew > D_rs_tuse) or (D_rs == M_wa and M_tnew > D_rs_tuse)); stall_rt identical with rt fields.
REQ-020 SHALL treat register 0 as never hazardous; D_*_tuse = 3 SHALL never cause stall.
REQ-021 SHALL compute stall_md = D_md and (busy or E_start).
REQ-022 SHALL drive stall = stall_rs or stall_rt or stall_md combinationally, same cycle as inputs.
REQ-023 SHALL drive DE_clr equal to stall; M/W and E/M registers never stalled.
REQ-024 SHALL implement FSM states IDLE, MULT, DIV; busy = (state != IDLE), registered.
REQ-025 IDLE: E_start=1 and E_is_div=0 -> MULT, md_cnt <= 5; E_start=1 and E_is_div=1 -> DIV, md_cnt <= 10.
REQ-026 MULT/DIV: md_cnt decrements by 1 per cycle; when md_cnt == 1 -> IDLE, md_cnt <= 0.
REQ-027 E_start while busy SHALL be ignored (state, md_cnt unchanged).
REQ-028 md_cnt SHALL be 0 whenever state is IDLE.
REQ-029 stall_cnt SHALL increment by 1 on each rising edge where stall = 1; saturate at 0xFFFFFFFF.
REQ-030 Simultaneous register hazard and md hazard SHALL count as one stall cycle.

Reset
REQ-031 rst=1 at rising edge SHALL force state IDLE, busy 0, md_cnt 0, stall_cnt 0, including mid-operation.
REQ-032 During rst, stall/DE_clr remain combinational functions of inputs with busy = 0.

Verification
REQ-033 Load-use: D_rs=5, D_rs_tuse=0, E_wa=5, E_tnew=2 -> stall=1, DE_clr=1; next cycle E_wa=0, M_wa=5, M_tnew=1 -> stall=1; then M_tnew=0 -> stall=0; stall_cnt=2.
REQ-034 Zero register: D_rs=0, E_wa=0, E_tnew=2, D_rs_tuse=0 -> stall=0.
REQ-035 Mult: E_start=1, E_is_div=0 one cycle -> busy=1, md_cnt 5,4,3,2,1 then busy=0 after 5 cycles; D_md=1 throughout -> stall=1 every cycle incl. E_start cycle (6 stall cycles).
REQ-036 Div: E_start=1, E_is_div=1 -> busy held 10 cycles; second E_start at cycle 3 ignored, md_cnt continues 7.
REQ-037 Reset mid-div: rst=1 at md_cnt=6 -> next cycle busy=0, md_cnt=0, stall_cnt=0; D_md=1 with E_start=0 -> stall=0.
REQ-038 No-use: D_rt_tuse=3, D_rt=8, E_wa=8, E_tnew=2 -> stall=0, stall_cnt unchanged.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose:
//   Hazard controller for the five-stage pipeline. It detects register
//   read-after-write hazards between the D stage and the E/M stages using the
//   Tuse/Tnew scheme. It also tracks occupancy of the multi-cycle mult/div unit
//   and counts stall cycles for performance monitoring.
//
// Handshake / timing:
//   There is no valid/ready handshake. stall and DE_clr are purely
//   combinational functions of the current-cycle inputs and the registered busy
//   flag, so the pipeline sees them in the same cycle. Everything else is
//   registered on the rising edge of clk.
//
// Ports:
//   clk        in   1  pipeline clock, rising edge
//   rst        in   1  synchronous, active-high reset
//   D_rs       in   5  rs field of D-stage instruction
//   D_rt       in   5  rt field of D-stage instruction
//   D_rs_tuse  in   2  cycles until rs is consumed (3 = not used)
//   D_rt_tuse  in   2  cycles until rt is consumed (3 = not used)
//   E_wa       in   5  destination register of E-stage instruction (0 = none)
//   E_tnew     in   2  cycles until E-stage result is available
//   M_wa       in   5  destination register of M-stage instruction
//   M_tnew     in   2  cycles until M-stage result is available
//   D_md       in   1  D-stage instruction uses mult/div or HI/LO
//   E_start    in   1  mult/div instruction issuing in E this cycle
//   E_is_div   in   1  qualifies E_start: 1 = div, 0 = mult
//   stall      out  1  freeze PC and F/D register
//   DE_clr     out  1  load a bubble into the D/E register
//   busy       out  1  mult/div unit occupied (registered)
//   md_cnt     out  4  remaining mult/div cycles (registered)
//   stall_cnt  out 32  saturating count of stall cycles since reset
//   md_state   out  2  mult/div FSM state for observation (0 IDLE, 1 MULT, 2 DIV)
// ----------------------------------------------------------------------------
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_rs_tuse,
    input  logic [1:0]  D_rt_tuse,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    input  logic        D_md,
    input  logic        E_start,
    input  logic        E_is_div,
    output logic        stall,
    output logic        DE_clr,
    output logic        busy,
    output logic [3:0]  md_cnt,
    output logic [31:0] stall_cnt,
    output logic [1:0]  md_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } md_state_e;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    md_state_e   state_q, state_d;
    logic [3:0]  md_cnt_q, md_cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic stall_rs, stall_rt, stall_md;
    logic busy_eff;

    // ------------------------------------------------------------------
    // Hazard detection. A tuse of 3 never stalls: the largest Tnew is 3,
    // and a strict greater-than comparison cannot exceed 3. Register 0 is
    // excluded explicitly.
    // ------------------------------------------------------------------
    always_comb begin
        stall_rs = (D_rs != 5'd0) &&
                   (((D_rs == E_wa) && (E_tnew > D_rs_tuse)) ||
                    ((D_rs == M_wa) && (M_tnew > D_rs_tuse)));
        stall_rt = (D_rt != 5'd0) &&
                   (((D_rt == E_wa) && (E_tnew > D_rt_tuse)) ||
                    ((D_rt == M_wa) && (M_tnew > D_rt_tuse)));
        // While rst is asserted the unit is treated as free. A reset that
        // arrives mid-operation then cannot hold the front end frozen.
        busy_eff = busy_q && !rst;
        stall_md = D_md && (busy_eff || E_start);
        stall    = stall_rs || stall_rt || stall_md;
        DE_clr   = stall;
    end

    // ------------------------------------------------------------------
    // Mult/div occupancy FSM next-state and stall counter.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (E_start) begin
                    state_d  = E_is_div ? DIV : MULT;
                    md_cnt_d = E_is_div ? DIV_CYCLES : MULT_CYCLES;
                end
            end
            MULT, DIV: begin
                // A new E_start while occupied is ignored.
                if (md_cnt_q == 4'd1) begin
                    state_d  = IDLE;
                    md_cnt_d = 4'd0;
                end else begin
                    md_cnt_d = md_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                md_cnt_d = 4'd0;
            end
        endcase
        busy_d = (state_d != IDLE);

        // A cycle with both a register and an md hazard counts once.
        // The counter saturates instead of wrapping.
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            md_cnt_q    <= 4'd0;
            busy_q      <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign busy      = busy_q;
    assign md_cnt    = md_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign md_state  = state_q;

endmodule
